// File: rtl/sdram_req_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_req_arbiter
//
// Shares the single byte-wide SDRAM user port between two requesters:
//   port 0 : pattern tester
//   port 1 : UART memory monitor
// One access is in flight at a time. Ties are broken round-robin. The SDRAM
// side signals are registered at grant time and held for the whole slot, and
// read data is returned on the requester's rdata together with a done pulse.
//
// Slot timeline (gnt cycle = g):
//   g            ACCESS : gnt pulse, sdram_we reflects the request
//   g+1..g+LAT   WAIT   : sdram_we forced low, addr/din/aux held
//   g+LAT+1      DONE   : done pulse, rdata updated for reads
//   g+LAT+2      IDLE   : earliest point a new request is sampled
//
// Ports:
//   clk, rst            reference clock, synchronous active-high reset
//   sdram_ready         controller initialisation complete
//   rN_req/we/aux/addr/din   request fields from requester N
//   rN_gnt, rN_done     one-cycle pulses: request captured / access complete
//   rN_rdata            last byte read on behalf of requester N
//   sdram_addr/din/we/aux    registered controller inputs
//   sdram_dout          16-bit controller read data
// -----------------------------------------------------------------------------
module sdram_req_arbiter #(
  parameter int LAT    = 2,
  parameter int ADDR_W = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sdram_ready,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic              r0_aux,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [7:0]        r0_din,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic              r1_aux,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [7:0]        r1_din,
  output logic              r0_gnt,
  output logic              r1_gnt,
  output logic              r0_done,
  output logic              r1_done,
  output logic [7:0]        r0_rdata,
  output logic [7:0]        r1_rdata,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [7:0]        sdram_din,
  output logic              sdram_we,
  output logic              sdram_aux,
  input  logic [15:0]       sdram_dout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_t              state_q;
  logic                last_gnt_q;
  logic                win_id_q;
  logic                win_we_q;
  logic [3:0]          cnt_q;
  logic [1:0]          gnt_q;
  logic [1:0]          done_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          din_q;
  logic                we_q;
  logic                aux_q;
  logic [1:0][7:0]     rdata_q;

  // Winner selection and its request fields, evaluated every cycle but only
  // consumed in IDLE.
  logic                any_req;
  logic                win_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [7:0]          din_d;
  logic                we_d;
  logic                aux_d;
  logic [7:0]          rbyte_d;

  always_comb begin
    any_req = r0_req | r1_req;
    // With both requesting, the port that did not win last time goes next;
    // with a single requester, that requester wins.
    win_d   = (r0_req && r1_req) ? ~last_gnt_q : r1_req;
    addr_d  = win_d ? r1_addr : r0_addr;
    din_d   = win_d ? r1_din  : r0_din;
    we_d    = win_d ? r1_we   : r0_we;
    aux_d   = win_d ? r1_aux  : r0_aux;
    // Byte lane follows the low address bit of the access in flight.
    rbyte_d = addr_q[0] ? sdram_dout[15:8] : sdram_dout[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_gnt_q <= 1'b1;
      win_id_q   <= 1'b0;
      win_we_q   <= 1'b0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      we_q       <= 1'b0;
      aux_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      // gnt and done are single-cycle pulses.
      gnt_q  <= '0;
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (sdram_ready && any_req) begin
            addr_q        <= addr_d;
            din_q         <= din_d;
            we_q          <= we_d;
            aux_q         <= aux_d;
            win_id_q      <= win_d;
            win_we_q      <= we_d;
            last_gnt_q    <= win_d;
            gnt_q[win_d]  <= 1'b1;
            state_q       <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // The write strobe is presented for the ACCESS cycle only.
          we_q    <= 1'b0;
          cnt_q   <= CNT_LOAD;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            done_q[win_id_q] <= 1'b1;
            if (!win_we_q) begin
              rdata_q[win_id_q] <= rbyte_d;
            end
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign r0_gnt     = gnt_q[0];
  assign r1_gnt     = gnt_q[1];
  assign r0_done    = done_q[0];
  assign r1_done    = done_q[1];
  assign r0_rdata   = rdata_q[0];
  assign r1_rdata   = rdata_q[1];
  assign sdram_addr = addr_q;
  assign sdram_din  = din_q;
  assign sdram_we   = we_q;
  assign sdram_aux  = aux_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// -----------------------------------------------------------------------------
// Directed bench for sdram_req_arbiter (LAT=2, ADDR_W=21).
// Inputs are driven and outputs sampled on the falling clock edge; one
// falling edge is one cycle. All expected values are written out by hand.
// -----------------------------------------------------------------------------
module tb_sdram_req_arbiter;

  localparam int LAT    = 2;
  localparam int ADDR_W = 21;

  logic              clk = 1'b0;
  logic              rst;
  logic              sdram_ready;
  logic              r0_req, r0_we, r0_aux;
  logic [ADDR_W-1:0] r0_addr;
  logic [7:0]        r0_din;
  logic              r1_req, r1_we, r1_aux;
  logic [ADDR_W-1:0] r1_addr;
  logic [7:0]        r1_din;
  logic              r0_gnt, r1_gnt, r0_done, r1_done;
  logic [7:0]        r0_rdata, r1_rdata;
  logic [ADDR_W-1:0] sdram_addr;
  logic [7:0]        sdram_din;
  logic              sdram_we, sdram_aux;
  logic [15:0]       sdram_dout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sdram_req_arbiter #(.LAT(LAT), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .sdram_ready (sdram_ready),
    .r0_req      (r0_req),
    .r0_we       (r0_we),
    .r0_aux      (r0_aux),
    .r0_addr     (r0_addr),
    .r0_din      (r0_din),
    .r1_req      (r1_req),
    .r1_we       (r1_we),
    .r1_aux      (r1_aux),
    .r1_addr     (r1_addr),
    .r1_din      (r1_din),
    .r0_gnt      (r0_gnt),
    .r1_gnt      (r1_gnt),
    .r0_done     (r0_done),
    .r1_done     (r1_done),
    .r0_rdata    (r0_rdata),
    .r1_rdata    (r1_rdata),
    .sdram_addr  (sdram_addr),
    .sdram_din   (sdram_din),
    .sdram_we    (sdram_we),
    .sdram_aux   (sdram_aux),
    .sdram_dout  (sdram_dout)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_req(input int port, input logic req, input logic we, input logic aux,
                         input logic [ADDR_W-1:0] addr, input logic [7:0] din);
    if (port == 0) begin
      r0_req = req; r0_we = we; r0_aux = aux; r0_addr = addr; r0_din = din;
    end else begin
      r1_req = req; r1_we = we; r1_aux = aux; r1_addr = addr; r1_din = din;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // One isolated access from a single requester, starting in IDLE.
  task automatic access(input int port, input logic we, input logic aux,
                        input logic [ADDR_W-1:0] addr, input logic [7:0] din,
                        input logic [15:0] dout,
                        input logic [7:0] exp_r0, input logic [7:0] exp_r1);
    set_req(port, 1'b1, we, aux, addr, din);
    sdram_dout = dout;
    cyc();
    check("gnt0", {31'd0, r0_gnt}, (port == 0) ? 32'd1 : 32'd0);
    check("gnt1", {31'd0, r1_gnt}, (port == 1) ? 32'd1 : 32'd0);
    check("acc_addr", 32'(sdram_addr), 32'(addr));
    check("acc_we", {31'd0, sdram_we}, {31'd0, we});
    check("acc_din", {24'd0, sdram_din}, {24'd0, din});
    check("acc_aux", {31'd0, sdram_aux}, {31'd0, aux});
    // Requester is free to scribble on its fields once granted.
    set_req(port, 1'b0, ~we, ~aux, ~addr, ~din);
    for (int i = 0; i < LAT; i++) begin
      cyc();
      check("wait_done", {30'd0, r1_done, r0_done}, 32'd0);
      check("wait_we", {31'd0, sdram_we}, 32'd0);
      check("wait_addr", 32'(sdram_addr), 32'(addr));
      check("wait_aux", {31'd0, sdram_aux}, {31'd0, aux});
    end
    cyc();
    check("done0", {31'd0, r0_done}, (port == 0) ? 32'd1 : 32'd0);
    check("done1", {31'd0, r1_done}, (port == 1) ? 32'd1 : 32'd0);
    check("rdata0", {24'd0, r0_rdata}, {24'd0, exp_r0});
    check("rdata1", {24'd0, r1_rdata}, {24'd0, exp_r1});
    $display("txn port=%0d we=%0d addr=0x%06h din=0x%02h rdata0=0x%02h rdata1=0x%02h",
             port, we, addr, din, r0_rdata, r1_rdata);
    cyc();
    check("idle_done", {30'd0, r1_done, r0_done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; sdram_ready = 1'b1; sdram_dout = 16'h0000;
    set_req(0, 1'b0, 1'b0, 1'b0, '0, 8'h00);
    set_req(1, 1'b0, 1'b0, 1'b0, '0, 8'h00);
    apply_reset();
    cyc();

    // Reset state.
    check("rst_gnt", {30'd0, r1_gnt, r0_gnt}, 32'd0);
    check("rst_done", {30'd0, r1_done, r0_done}, 32'd0);
    check("rst_we", {31'd0, sdram_we}, 32'd0);
    check("rst_addr", 32'(sdram_addr), 32'd0);
    check("rst_din", {24'd0, sdram_din}, 32'd0);
    check("rst_aux", {31'd0, sdram_aux}, 32'd0);
    check("rst_rdata", {16'd0, r1_rdata, r0_rdata}, 32'd0);

    // Single read: odd address picks the high byte.
    access(0, 1'b0, 1'b0, 21'h000101, 8'h00, 16'hA55A, 8'hA5, 8'h00);
    // r1 read, even address picks the low byte.
    access(1, 1'b0, 1'b0, 21'h000010, 8'h77, 16'h12C3, 8'hA5, 8'hC3);
    // r1 write to top address with aux: rdata must not move.
    access(1, 1'b1, 1'b1, 21'h1FFFFF, 8'h3C, 16'hFFFF, 8'hA5, 8'hC3);

    // Contention from reset: r0 first, then alternate every LAT+3 cycles.
    rst = 1'b1;
    cyc();
    set_req(0, 1'b1, 1'b0, 1'b0, 21'h000020, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b0, 21'h000021, 8'h00);
    sdram_dout = 16'h5A69;
    cyc();
    rst = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      cyc();
      check("rr_gnt0", {31'd0, r0_gnt}, (c % 10 == 1) ? 32'd1 : 32'd0);
      check("rr_gnt1", {31'd0, r1_gnt}, (c % 10 == 6) ? 32'd1 : 32'd0);
      check("rr_done0", {31'd0, r0_done}, (c % 10 == 4) ? 32'd1 : 32'd0);
      check("rr_done1", {31'd0, r1_done}, (c % 10 == 9) ? 32'd1 : 32'd0);
      if (r0_gnt || r1_gnt) $display("txn contention cycle=%0d gnt0=%0d gnt1=%0d", c, r0_gnt, r1_gnt);
    end
    check("rr_rdata0", {24'd0, r0_rdata}, 32'h69);
    check("rr_rdata1", {24'd0, r1_rdata}, 32'h5A);
    set_req(0, 1'b0, 1'b0, 1'b0, '0, 8'h00);
    set_req(1, 1'b0, 1'b0, 1'b0, '0, 8'h00);

    // Not ready: pending write is held off for 20 cycles.
    sdram_ready = 1'b0;
    apply_reset();
    set_req(0, 1'b1, 1'b1, 1'b0, 21'h000444, 8'h99);
    for (int c = 0; c < 20; c++) begin
      cyc();
      check("nr_gnt", {30'd0, r1_gnt, r0_gnt}, 32'd0);
      check("nr_we", {31'd0, sdram_we}, 32'd0);
    end
    sdram_ready = 1'b1;
    cyc();
    check("nr_gnt_after", {31'd0, r0_gnt}, 32'd1);
    check("nr_we_after", {31'd0, sdram_we}, 32'd1);
    check("nr_din_after", {24'd0, sdram_din}, 32'h99);
    set_req(0, 1'b0, 1'b0, 1'b0, '0, 8'h00);
    for (int i = 0; i <= LAT; i++) cyc();
    check("nr_done", {31'd0, r0_done}, 32'd1);
    $display("txn not-ready write port=0 addr=0x000444 din=0x99");
    cyc();

    // Ready drops during the WAIT of an r1 read; r0 is pending meanwhile.
    set_req(1, 1'b1, 1'b0, 1'b0, 21'h000003, 8'h00);
    sdram_dout = 16'hBEEF;
    cyc();
    check("rd_gnt1", {31'd0, r1_gnt}, 32'd1);
    set_req(1, 1'b0, 1'b0, 1'b0, '0, 8'h00);
    set_req(0, 1'b1, 1'b0, 1'b0, 21'h000006, 8'h00);
    cyc();
    sdram_ready = 1'b0;
    cyc();
    check("rd_done_early", {30'd0, r1_done, r0_done}, 32'd0);
    cyc();
    check("rd_done1", {31'd0, r1_done}, 32'd1);
    check("rd_rdata1", {24'd0, r1_rdata}, 32'hBE);
    $display("txn ready-drop read port=1 addr=0x000003 rdata1=0x%02h", r1_rdata);
    for (int c = 0; c < 8; c++) begin
      cyc();
      check("rd_hold_gnt", {30'd0, r1_gnt, r0_gnt}, 32'd0);
    end
    sdram_ready = 1'b1;
    sdram_dout = 16'h1234;
    cyc();
    check("rd_gnt0", {31'd0, r0_gnt}, 32'd1);
    set_req(0, 1'b0, 1'b0, 1'b0, '0, 8'h00);
    for (int i = 0; i <= LAT; i++) cyc();
    check("rd_done0", {31'd0, r0_done}, 32'd1);
    check("rd_rdata0", {24'd0, r0_rdata}, 32'h34);
    cyc();

    // last_gnt is now 0, so without the reset the next tie would go to r1.
    // Reset in the ACCESS cycle of an r0 write.
    set_req(0, 1'b1, 1'b1, 1'b1, 21'h000055, 8'hE1);
    cyc();
    check("rm_gnt0", {31'd0, r0_gnt}, 32'd1);
    check("rm_we", {31'd0, sdram_we}, 32'd1);
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 1'b0, '0, 8'h00);
    cyc();
    check("rm_done", {30'd0, r1_done, r0_done}, 32'd0);
    check("rm_we_off", {31'd0, sdram_we}, 32'd0);
    check("rm_addr", 32'(sdram_addr), 32'd0);
    check("rm_aux", {31'd0, sdram_aux}, 32'd0);
    check("rm_rdata", {16'd0, r1_rdata, r0_rdata}, 32'd0);
    rst = 1'b0;
    set_req(0, 1'b1, 1'b0, 1'b0, 21'h000100, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b0, 21'h000200, 8'h00);
    cyc();
    check("rm_tie_gnt0", {31'd0, r0_gnt}, 32'd1);
    check("rm_tie_gnt1", {31'd0, r1_gnt}, 32'd0);
    check("rm_no_done", {30'd0, r1_done, r0_done}, 32'd0);
    $display("txn reset-mid-op then tie gnt0=%0d gnt1=%0d", r0_gnt, r1_gnt);
    set_req(0, 1'b0, 1'b0, 1'b0, '0, 8'h00);
    set_req(1, 1'b0, 1'b0, 1'b0, '0, 8'h00);
    for (int i = 0; i < LAT + 3; i++) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdram_req_arbiter.md
Name: sdram_req_arbiter

Overview:
- Shares the single byte-wide SDRAM user port (addr/din/dout/we/aux) between two independent requesters: port 0 is the pattern tester and port 1 is the UART memory monitor.
- Runs in the SDRAM controller's reference-clock domain (14 MHz).
- Grants one access at a time with round-robin fairness.
- Holds the SDRAM-side signals stable for a fixed slot and returns read data with a completion pulse.

Parameters:
- LAT, 2, number of clk cycles after the access cycle before sdram_dout is valid (range 1..15).
- ADDR_W, 21, byte address width.

Ports:
- clk  in  1  14 MHz reference clock (SDRAM clkref)
- rst  in  1  synchronous reset, active-high
- sdram_ready  in  1  SDRAM initialisation complete
- r0_req, r1_req  in  1  access request; held high until gnt
- r0_we, r1_we  in  1  1 = write, 0 = read
- r0_aux, r1_aux  in  1  aux bank select
- r0_addr, r1_addr  in  ADDR_W  byte address
- r0_din, r1_din  in  8  write data
- r0_gnt, r1_gnt  out  1  one-cycle pulse: request accepted, fields captured
- r0_done, r1_done  out  1  one-cycle pulse: access complete
- r0_rdata, r1_rdata  out  8  read data, valid from done and held until the next read completes on that port
- sdram_addr  out  ADDR_W  to controller addr
- sdram_din  out  8  to controller din
- sdram_we  out  1  to controller we
- sdram_aux  out  1  to controller aux
- sdram_dout  in  16  from controller dout

Behaviour:
- Reset state:
  - State is IDLE; all gnt/done are 0; sdram_we=0.
  - sdram_addr, sdram_din, sdram_aux, r0_rdata and r1_rdata are 0.
  - Round-robin pointer is last_gnt=1, so port 0 wins the first tie.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - If sdram_ready=1 and any req=1, select the winner. If only one port requests, it wins. If both request, the port other than last_gnt wins.
  - On the next edge: register the winner's addr, din, we and aux onto the sdram_* outputs; latch the winner id and we; set last_gnt to the winner; assert that port's gnt; go to ACCESS.
  - If sdram_ready=0, no grant is issued and requests stay pending.
- ACCESS:
  - Exactly 1 cycle; gnt is high in this cycle only.
  - sdram_* outputs hold; next state is WAIT and the counter is loaded with LAT-1.
  - req inputs are ignored in every state except IDLE.
- WAIT:
  - Lasts LAT cycles. sdram_we is cleared to 0 on entry; sdram_addr, sdram_din and sdram_aux keep their values.
  - When the counter reaches 0, go to DONE.
  - On that same edge, if the access is a read, capture the byte into the winner's rdata: sdram_addr[0]=1 selects sdram_dout[15:8], otherwise sdram_dout[7:0].
- DONE:
  - 1 cycle with the winner's done=1, then return to IDLE.
  - A write raises done without changing rdata.
- Timing:
  - gnt is high in the cycle after req is first sampled in IDLE.
  - done is high exactly LAT+1 cycles after the gnt cycle.
  - Minimum access period is LAT+3 cycles.
  - gnt and done are never high on both ports in the same cycle.
- Requester rules:
  - The requester must drop req no later than the DONE cycle; if req is still high in IDLE it is treated as a new request.
  - A requester may change its fields from the gnt cycle onward.
- sdram_ready falling mid-access: the current access completes normally; no new grant is issued until ready returns to 1.
- rst asserted mid-access: the access is abandoned immediately. No done is produced, sdram_we=0, and all outputs return to their reset values on the next cycle.
- Address width: addresses pass through unmodified. Address wrap-around is the requester's concern.

Test Plan:
- Single read, LAT=2: r0 reads 0x000101 with sdram_dout=0xA55A → r0_gnt in cycle 1; sdram_addr=0x000101 and sdram_we=0 from cycle 1 to done; r0_done in cycle 4; r0_rdata=0xA5.
- Single write: r1 writes 0x3C to 0x1FFFFF with aux=1 → sdram_we=1 only in the ACCESS cycle; sdram_din=0x3C; sdram_aux=1; r1_done 3 cycles after r1_gnt; r1_rdata unchanged.
- Contention: r0 and r1 both hold req continuously from reset → gnts alternate r0, r1, r0, r1, with gnt-to-gnt spacing of LAT+3 cycles; no port waits more than one slot.
- Not ready: r0_req=1 while sdram_ready=0 for 20 cycles → no gnt and sdram_we=0 throughout; gnt is high in the cycle after sdram_ready rises.
- Ready drop: sdram_ready falls in the WAIT cycle of an r1 read → r1_done still occurs on schedule with correct rdata; a pending r0 request waits until ready returns.
- Reset mid-op: rst asserted in the ACCESS cycle of an r0 write → no r0_done; sdram_we=0 and IDLE the next cycle; the next tie grants r0 first.
